// File: rtl/irq_ctrl.sv
// Interrupt controller: priority selection of masked pending sources with a
// two-state request/acknowledge handshake toward the processor.
//
// Build option: define IRQ_CTRL_EDGE_EN to make sources rising-edge
// triggered with sticky pending bits. Without it, sources are level
// triggered and a source that is still high re-pends on every cycle.
module irq_ctrl #(
  parameter int NUM_SRC = 32
) (
  input  logic               CLK,
  input  logic               RES,
  input  logic [NUM_SRC-1:0] src,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  input  logic               irq_ack,
  input  logic [4:0]         irq_ack_id,
  output logic               irq,
  output logic [4:0]         irq_id,
  output logic [NUM_SRC-1:0] pending,
  output logic               ack_err
);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_stateNext;
  logic [4:0]         r_irqId;
  logic [4:0]         w_irqIdNext;
  logic               r_ackErr;
  logic               w_ackErrNext;
  logic [NUM_SRC-1:0] r_mask;
  logic [NUM_SRC-1:0] r_pending;
  logic [NUM_SRC-1:0] w_event;
  logic [NUM_SRC-1:0] w_masked;
  logic [NUM_SRC-1:0] w_ackOneHot;
  logic [NUM_SRC-1:0] w_clr;
  logic               w_ackIdValid;
  logic               w_clrEn;
  logic [4:0]         w_lowestId;

`ifdef IRQ_CTRL_EDGE_EN
  logic [NUM_SRC-1:0] r_srcPrev;

  // Edge history follows src every cycle, including during reset, so a
  // source already high when reset is released does not look like an edge.
  always_ff @(posedge CLK) begin
    r_srcPrev <= src;
  end

  assign w_event = src & ~r_srcPrev;
`else
  assign w_event = src;
`endif

  assign w_masked = r_pending & r_mask;

  // Decode the acknowledged id; ids beyond the implemented sources decode to
  // nothing, which is also how an out-of-range acknowledge is detected.
  always_comb begin
    w_ackOneHot = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (irq_ack_id == 5'(i)) begin
        w_ackOneHot[i] = 1'b1;
      end
    end
  end

  assign w_ackIdValid = |w_ackOneHot;

  // Lowest set index wins, so scan from the top and let lower indices
  // overwrite the result.
  always_comb begin
    w_lowestId = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_masked[i]) begin
        w_lowestId = 5'(i);
      end
    end
  end

  // Request/acknowledge handshake: next state, latched id, error flag and
  // whether this edge clears the acknowledged pending bit.
  always_comb begin
    w_stateNext  = r_state;
    w_irqIdNext  = r_irqId;
    w_ackErrNext = r_ackErr;
    w_clrEn      = 1'b0;
    case (r_state)
      IDLE: begin
        if (irq_ack) begin
          w_ackErrNext = 1'b1;
        end else if (|w_masked) begin
          w_stateNext = REQ;
          w_irqIdNext = w_lowestId;
        end
      end
      REQ: begin
        if (irq_ack) begin
          w_stateNext = IDLE;
          w_clrEn     = 1'b1;
          if (!w_ackIdValid || (irq_ack_id != r_irqId)) begin
            w_ackErrNext = 1'b1;
          end
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  assign w_clr = w_clrEn ? w_ackOneHot : '0;

  // All architectural state; a new event on the same edge as a clear keeps
  // the bit set.
  always_ff @(posedge CLK) begin
    if (RES) begin
      r_state   <= IDLE;
      r_irqId   <= '0;
      r_ackErr  <= 1'b0;
      r_pending <= '0;
      r_mask    <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_irqId   <= w_irqIdNext;
      r_ackErr  <= w_ackErrNext;
      r_pending <= (r_pending & ~w_clr) | w_event;
      if (mask_we) begin
        r_mask <= mask_wdata;
      end
    end
  end

  assign irq     = (r_state == REQ);
  assign irq_id  = r_irqId;
  assign pending = r_pending;
  assign ack_err = r_ackErr;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios followed by random
// traffic, all compared against a behavioural model of the controller.
module tb_irq_ctrl;

  logic        CLK = 1'b0;
  logic        RES;
  logic [31:0] src;
  logic        mask_we;
  logic [31:0] mask_wdata;
  logic        irq_ack;
  logic [4:0]  irq_ack_id;
  logic        irq;
  logic [4:0]  irq_id;
  logic [31:0] pending;
  logic        ack_err;

  int testCount = 0;
  int failCount = 0;

  // Behavioural model state
  bit [31:0] mPend;
  bit [31:0] mMask;
  bit [31:0] mPrev;
  bit        mReq;
  int        mId;
  bit        mErr;
  bit [31:0] curSrc;

  irq_ctrl #(.NUM_SRC(32)) dut (
    .CLK        (CLK),
    .RES        (RES),
    .src        (src),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .irq_ack    (irq_ack),
    .irq_ack_id (irq_ack_id),
    .irq        (irq),
    .irq_id     (irq_id),
    .pending    (pending),
    .ack_err    (ack_err)
  );

  always #5 CLK = ~CLK;

  // Compare one observed value against its expectation
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int lowestSet(input bit [31:0] v);
    for (int i = 0; i < 32; i++) begin
      if (v[i]) return i;
    end
    return 0;
  endfunction

  // One clock edge of the reference behaviour, from the inputs of that edge
  task automatic modelEdge(input bit r, input bit [31:0] s, input bit mwe,
                           input bit [31:0] mwd, input bit ack, input int aid);
    bit [31:0] events;
    bit [31:0] clearBits;
    bit [31:0] selectable;
    if (r) begin
      mReq  = 0;
      mId   = 0;
      mPend = 0;
      mMask = 0;
      mErr  = 0;
      mPrev = s;
      return;
    end
`ifdef IRQ_CTRL_EDGE_EN
    events = s & ~mPrev;
`else
    events = s;
`endif
    mPrev      = s;
    clearBits  = 0;
    selectable = mPend & mMask;
    if (mReq) begin
      if (ack) begin
        if (aid < 32) clearBits = 32'd1 << aid;
        if (aid != mId) mErr = 1;
        mReq = 0;
      end
    end else if (ack) begin
      mErr = 1;
    end else if (selectable != 0) begin
      mReq = 1;
      mId  = lowestSet(selectable);
    end
    mPend = (mPend & ~clearBits) | events;
    if (mwe) mMask = mwd;
  endtask

  // Drive one cycle of inputs, advance the model, compare after the edge
  task automatic applyStimulus(input bit r, input bit [31:0] s, input bit mwe,
                               input bit [31:0] mwd, input bit ack, input int aid);
    RES        = r;
    src        = s;
    mask_we    = mwe;
    mask_wdata = mwd;
    irq_ack    = ack;
    irq_ack_id = 5'(aid);
    curSrc     = s;
    @(posedge CLK);
    modelEdge(r, s, mwe, mwd, ack, aid);
    #1;
    checkOutput("irq", {31'd0, irq}, {31'd0, mReq});
    checkOutput("pending", pending, mPend);
    checkOutput("ack_err", {31'd0, ack_err}, {31'd0, mErr});
    if (mReq) checkOutput("irq_id", {27'd0, irq_id}, 32'(mId));
  endtask

  task automatic idle(input int n, input bit [31:0] s);
    for (int i = 0; i < n; i++) applyStimulus(0, s, 0, 0, 0, 0);
  endtask

  initial begin
    RES = 1; src = 0; mask_we = 0; mask_wdata = 0; irq_ack = 0; irq_ack_id = 0;
    curSrc = 0;
    mPend = 0; mMask = 0; mPrev = 0; mReq = 0; mId = 0; mErr = 0;

    // Reset state
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("reset_irq", {31'd0, irq}, 0);
    checkOutput("reset_pending", pending, 0);
    checkOutput("reset_ack_err", {31'd0, ack_err}, 0);

    // Single source, enable, acknowledge
    applyStimulus(0, 0, 1, 32'h1, 0, 0);
    idle(6, 0);
    applyStimulus(0, 32'h1, 0, 0, 0, 0);
    checkOutput("s030_pend", pending, 32'h1);
    checkOutput("s030_irq_early", {31'd0, irq}, 0);
    applyStimulus(0, 32'h1, 0, 0, 0, 0);
    checkOutput("s030_irq", {31'd0, irq}, 1);
    checkOutput("s030_id", {27'd0, irq_id}, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("s030_irq_off", {31'd0, irq}, 0);
    checkOutput("s030_pend_off", pending, 0);

    // Two simultaneous sources: priority and one idle cycle between requests
    applyStimulus(0, 0, 1, 32'hFFFF_FFFF, 0, 0);
    applyStimulus(0, 32'h88, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("s031_id3", {27'd0, irq_id}, 3);
    applyStimulus(0, 0, 0, 0, 1, 3);
    checkOutput("s031_gap", {31'd0, irq}, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("s031_irq7", {31'd0, irq}, 1);
    checkOutput("s031_id7", {27'd0, irq_id}, 7);
    applyStimulus(0, 0, 0, 0, 1, 7);
    checkOutput("s031_done", {31'd0, irq}, 0);
    checkOutput("s031_noerr", {31'd0, ack_err}, 0);

    // Masked source held pending, released by a later mask write
    applyStimulus(0, 0, 1, 0, 0, 0);
    applyStimulus(0, 32'h20, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    idle(2, 0);
    checkOutput("s032_pend", pending, 32'h20);
    checkOutput("s032_quiet", {31'd0, irq}, 0);
    applyStimulus(0, 0, 1, 32'h20, 0, 0);
    checkOutput("s032_one_edge", {31'd0, irq}, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("s032_irq", {31'd0, irq}, 1);
    checkOutput("s032_id", {27'd0, irq_id}, 5);
    applyStimulus(0, 0, 0, 0, 1, 5);

    // Wrong-id acknowledge clears the named bit and sets the sticky error
    applyStimulus(0, 0, 1, 32'hFF, 0, 0);
    applyStimulus(0, 32'h14, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("s033_id2", {27'd0, irq_id}, 2);
    applyStimulus(0, 0, 0, 0, 1, 4);
    checkOutput("s033_pend", pending, 32'h4);
    checkOutput("s033_idle", {31'd0, irq}, 0);
    checkOutput("s033_err", {31'd0, ack_err}, 1);
    idle(3, 0);
    applyStimulus(0, 0, 0, 0, 1, 2);
    idle(2, 0);
    checkOutput("s033_err_held", {31'd0, ack_err}, 1);

    // Reset while a request is outstanding
    applyStimulus(0, 32'h40, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("s035_pre_irq", {31'd0, irq}, 1);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("s035_irq", {31'd0, irq}, 0);
    checkOutput("s035_pend", pending, 0);
    checkOutput("s035_err", {31'd0, ack_err}, 0);

    // Source held high across reset release
    applyStimulus(1, 32'h2, 0, 0, 0, 0);
    applyStimulus(0, 32'h2, 1, 32'h2, 0, 0);
    checkOutput("s034_first", {31'd0, irq}, 0);
    applyStimulus(0, 32'h2, 0, 0, 0, 0);
`ifdef IRQ_CTRL_EDGE_EN
    checkOutput("s034_edge_irq", {31'd0, irq}, 0);
`else
    checkOutput("s034_level_irq", {31'd0, irq}, 1);
    checkOutput("s034_level_id", {27'd0, irq_id}, 1);
`endif
    applyStimulus(0, 0, 0, 0, mReq, 1);
    idle(2, 0);

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      bit [31:0] s;
      bit        r;
      bit        mwe;
      bit        ack;
      int        aid;
      s   = curSrc ^ ($urandom & $urandom & $urandom & $urandom);
      r   = ($urandom_range(0, 199) == 0);
      mwe = ($urandom_range(0, 19) == 0);
      ack = 0;
      aid = 0;
      if (mReq && $urandom_range(0, 2) == 0) begin
        ack = 1;
        aid = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 31)) : mId;
      end else if (!mReq && $urandom_range(0, 59) == 0) begin
        ack = 1;
        aid = int'($urandom_range(0, 31));
      end
      applyStimulus(r, s, mwe, $urandom, ack, aid);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
